// File: rtl/fused_cnn_pkg.sv
// Shared defaults for the fused CNN datapath blocks.
package fused_cnn_pkg;

    localparam int unsigned DATA_W_DEF     = 8;   // feature-map word width
    localparam int unsigned ADDR_W_DEF     = 13;  // IFM buffer address width
    localparam int unsigned DEPTH_DEF      = 4;   // fetch FIFO entries
    localparam int unsigned WINDOW_LEN_DEF = 45;  // 3x3x5 kernel window

endpackage

// File: rtl/sync_fifo.sv
// Small register-based FIFO holding returned feature-map words ahead of the PE.
// The head entry is read straight from storage, so there is no path from the
// write data to the read data.
module sync_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DATA_W-1:0]        wdata_i,
    output logic [DATA_W-1:0]        rdata_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic              do_pop;

    assign do_pop  = pop_i && (level_q != '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // Storage, pointers and occupancy; flush empties the FIFO without touching storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // The upstream credit check makes a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        (push_i && !flush_i) |-> (level_q != LVL_W'(DEPTH)));

endmodule

// File: rtl/ifm_fetch_buffer.sv
// IFM fetch buffer: turns PE address requests into SRAM reads, absorbs the
// one-cycle read latency in a small FIFO and tags the last word of each window.
// A request is only accepted when a FIFO slot is guaranteed for its data, so
// the FIFO can never overflow and backpressure reaches the address controller.
module ifm_fetch_buffer
    import fused_cnn_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned WINDOW_LEN = WINDOW_LEN_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic                     addr_valid_i,
    output logic                     addr_ready_o,
    output logic                     mem_re_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    input  logic [DATA_W-1:0]        mem_rdata_i,
    output logic [DATA_W-1:0]        pe_data_o,
    output logic                     pe_valid_o,
    input  logic                     pe_ready_i,
    output logic                     pe_last_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned           LVL_W    = $clog2(DEPTH) + 1;
    localparam int unsigned           CNT_W    = $clog2(WINDOW_LEN);
    localparam logic [LVL_W:0]        DEPTH_L  = (LVL_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]      WIN_LAST = CNT_W'(WINDOW_LEN - 1);

    logic              inflight_q, inflight_d;
    logic [CNT_W-1:0]  win_cnt_q, win_cnt_d;
    logic [LVL_W-1:0]  level;
    logic [LVL_W:0]    credit_used;
    logic              accept;
    logic              push;
    logic              pop;
    logic              flush;

    // Words already buffered plus the one possibly on its way back from SRAM.
    assign credit_used  = {1'b0, level} + {{LVL_W{1'b0}}, inflight_q};
    assign addr_ready_o = reset_n && en && (credit_used < DEPTH_L);
    assign accept       = addr_valid_i && addr_ready_o;

    assign mem_re_o     = accept;
    assign mem_addr_o   = accept ? addr_i : '0;

    // Read data returning while disabled belongs to a flushed request and is dropped.
    assign flush        = !en;
    assign push         = inflight_q && en;
    assign pop          = pe_valid_o && pe_ready_i;

    assign pe_valid_o   = (level != '0);
    assign pe_last_o    = pe_valid_o && (win_cnt_q == WIN_LAST);
    assign level_o      = level;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush_i (flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (mem_rdata_i),
        .rdata_o (pe_data_o),
        .level_o (level)
    );

    // Next-state for the read-in-flight flag and the window position counter.
    always_comb begin
        inflight_d = accept;
        win_cnt_d  = win_cnt_q;
        if (flush) begin
            win_cnt_d = '0;
        end else if (pop) begin
            win_cnt_d = (win_cnt_q == WIN_LAST) ? '0 : win_cnt_q + 1'b1;
        end
    end

    // Credit and window state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight_q <= 1'b0;
            win_cnt_q  <= '0;
        end else begin
            inflight_q <= inflight_d;
            win_cnt_q  <= win_cnt_d;
        end
    end

endmodule

// File: tb/tb_ifm_fetch_buffer.sv
`timescale 1ns/1ps
module tb_ifm_fetch_buffer;
    import fused_cnn_pkg::*;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int WIN    = 45;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              en = 1'b1;
    logic [ADDR_W-1:0] addr_i = '0;
    logic              addr_valid_i = 1'b0;
    logic              addr_ready_o;
    logic              mem_re_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_rdata_i = '0;
    logic [DATA_W-1:0] pe_data_o;
    logic              pe_valid_o;
    logic              pe_ready_i = 1'b0;
    logic              pe_last_o;
    logic [$clog2(DEPTH):0] level_o;

    ifm_fetch_buffer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .en           (en),
        .addr_i       (addr_i),
        .addr_valid_i (addr_valid_i),
        .addr_ready_o (addr_ready_o),
        .mem_re_o     (mem_re_o),
        .mem_addr_o   (mem_addr_o),
        .mem_rdata_i  (mem_rdata_i),
        .pe_data_o    (pe_data_o),
        .pe_valid_o   (pe_valid_o),
        .pe_ready_i   (pe_ready_i),
        .pe_last_o    (pe_last_o),
        .level_o      (level_o)
    );

    always #5 clk = ~clk;

    // SRAM model: data = addr[7:0] one cycle after the read, junk otherwise.
    always @(posedge clk) begin
        mem_rdata_i <= mem_re_o ? mem_addr_o[7:0] : 8'hEE;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   exp_idx = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_acc = 0;
    int   n_last = 0;
    int   max_level = 0;
    bit   seen_acc = 0, seen_valid = 0;
    int   acc_cyc = 0, valid_cyc = 0, rel_cyc = 0;
    bit   acc_s;
    int   a_s, acc0, last0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Stimulus side of the scoreboard: every accepted request queues its expected word.
    always @(negedge clk) begin
        if (reset_n) begin
            if (addr_valid_i && addr_ready_o) begin
                check("mem_re_on_accept", 32'(mem_re_o), 32'd1);
                check("mem_addr_on_accept", 32'(mem_addr_o), 32'(addr_i));
                exp_q.push_back('{d: addr_i[7:0], last: (exp_idx == WIN-1)});
                exp_idx = (exp_idx == WIN-1) ? 0 : exp_idx + 1;
                n_acc++;
                if (!seen_acc) begin
                    seen_acc = 1;
                    acc_cyc  = cyc;
                end
            end else begin
                check("mem_idle", 32'({mem_re_o, mem_addr_o}), 32'd0);
            end
        end
    end

    // Monitor side: compare every word the PE takes against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (int'(level_o) > max_level) max_level = int'(level_o);
            if (pe_valid_o && !seen_valid) begin
                seen_valid = 1;
                valid_cyc  = cyc;
            end
            if (pe_valid_o && pe_ready_i) begin
                check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("pe_data", 32'(pe_data_o), 32'(e.d));
                    check("pe_last", 32'(pe_last_o), 32'(e.last));
                end
                if (pe_last_o) n_last++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rdy: 0 = PE always ready, 1 = random, 2 = PE stalled
    task automatic stream(input int base, input int n, input int rdy);
        int  sent = 0;
        int  guard = 0;
        bit  acc;
        addr_i       = ADDR_W'(base);
        addr_valid_i = 1'b1;
        pe_ready_i   = (rdy == 0) ? 1'b1 : (rdy == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        while (sent < n && guard < 20 * n + 100) begin
            @(negedge clk);
            acc = addr_valid_i && addr_ready_o;
            tick();
            guard++;
            if (acc) begin
                sent++;
                addr_i = ADDR_W'(base + sent);
            end
            if (rdy == 1) pe_ready_i = 1'($urandom_range(0, 1));
        end
        addr_valid_i = 1'b0;
        check("stream_sent", 32'(sent), 32'(n));
    endtask

    task automatic drain();
        int g = 0;
        pe_ready_i = 1'b1;
        while ((exp_q.size() != 0 || level_o != 0) && g < 200) begin
            tick();
            g++;
        end
        tick();
        check("drain_sb_empty", 32'(exp_q.size()), 32'd0);
        check("drain_level", 32'(level_o), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pe_valid"},   32'(pe_valid_o),   32'd0);
        check({tag, "_pe_last"},    32'(pe_last_o),    32'd0);
        check({tag, "_mem_re"},     32'(mem_re_o),     32'd0);
        check({tag, "_addr_ready"}, 32'(addr_ready_o), 32'd0);
        check({tag, "_level"},      32'(level_o),      32'd0);
        check({tag, "_pe_data"},    32'(pe_data_o),    32'd0);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a pending request: nothing may be accepted.
        addr_valid_i = 1'b1;
        addr_i       = 13'd7;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        addr_valid_i = 1'b0;
        reset_n      = 1'b1;
        rel_cyc      = cyc;
        seen_acc     = 0;
        seen_valid   = 0;

        // Full window 0..44, PE always ready.
        last0 = n_last;
        stream(0, 45, 0);
        drain();
        check("first_accept_cycle", 32'(acc_cyc), 32'(rel_cyc));
        check("latency_acc_to_valid", 32'(valid_cyc - acc_cyc), 32'd2);
        check("win1_last_count", 32'(n_last - last0), 32'd1);

        // PE stalled with continuous requests: exactly DEPTH accepts.
        pe_ready_i   = 1'b0;
        acc0         = n_acc;
        a_s          = 100;
        addr_i       = ADDR_W'(a_s);
        addr_valid_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            acc_s = addr_valid_i && addr_ready_o;
            tick();
            if (acc_s) begin
                a_s++;
                addr_i = ADDR_W'(a_s);
            end
        end
        check("stall_accepts", 32'(n_acc - acc0), 32'd4);
        check("stall_ready_low", 32'(addr_ready_o), 32'd0);
        check("stall_level", 32'(level_o), 32'd4);
        addr_valid_i = 1'b0;
        drain();

        // Push and pop together at level 2 for 10 cycles.
        stream(200, 3, 2);
        pe_ready_i   = 1'b1;
        a_s          = 203;
        addr_i       = ADDR_W'(a_s);
        addr_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("steady_level", 32'(level_o), 32'd2);
            acc_s = addr_valid_i && addr_ready_o;
            tick();
            if (acc_s) begin
                a_s++;
                addr_i = ADDR_W'(a_s);
            end
        end
        addr_valid_i = 1'b0;
        drain();

        // One-cycle disable with level 3 and a read in flight.
        stream(300, 4, 2);
        check("flush_pre_level", 32'(level_o), 32'd3);
        en = 1'b0;
        @(negedge clk);
        check("flush_ready_low", 32'(addr_ready_o), 32'd0);
        tick();
        check("flush_level", 32'(level_o), 32'd0);
        check("flush_valid", 32'(pe_valid_o), 32'd0);
        exp_q.delete();
        exp_idx    = 0;
        en         = 1'b1;
        pe_ready_i = 1'b1;
        repeat (3) tick();
        check("flush_no_stale", 32'(pe_valid_o), 32'd0);
        last0 = n_last;
        stream(400, 45, 0);
        drain();
        check("flush_win_last_count", 32'(n_last - last0), 32'd1);

        // Asynchronous reset between clock edges, mid-stream.
        stream(500, 10, 0);
        addr_valid_i = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        exp_idx      = 0;
        addr_valid_i = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        last0 = n_last;
        stream(600, 90, 0);
        drain();
        check("midrst_last_count", 32'(n_last - last0), 32'd2);

        // Random PE backpressure over 1000 words.
        last0 = n_last;
        stream(1000, 1000, 1);
        drain();
        check("rand_last_count", 32'(n_last - last0), 32'd22);
        check("max_level_bound", 32'(max_level <= DEPTH), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ifm_fetch_buffer.md
IFM_FETCH_BUFFER -- requirements
Module: ifm_fetch_buffer

Interface
REQ-001 Parameter DATA_W, default 8, feature-map word width in bits.
REQ-002 Parameter ADDR_W, default 13, buffer address width; matches PE address controller.
REQ-003 Parameter DEPTH, default 4, output FIFO entries; power of two, at least 2.
REQ-004 Parameter WINDOW_LEN, default 45, words per kernel window (3x3x5).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  block enable; low = flush, shared with address controller en.
REQ-008 addr_i  input  ADDR_W  read address from PE address controller.
REQ-009 addr_valid_i  input  1  addr_i holds a request this cycle.
REQ-010 addr_ready_o  output  1  request accepted this cycle; drives controller valid/stall.
REQ-011 mem_re_o  output  1  SRAM read enable.
REQ-012 mem_addr_o  output  ADDR_W  SRAM read address.
REQ-013 mem_rdata_i  input  DATA_W  SRAM read data, valid exactly 1 cycle after mem_re_o.
REQ-014 pe_data_o  output  DATA_W  word presented to PE.
REQ-015 pe_valid_o  output  1  pe_data_o valid.
REQ-016 pe_ready_i  input  1  PE accepts word.
REQ-017 pe_last_o  output  1  qualifies pe_data_o as last word of a window.
REQ-018 level_o  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-019 addr_ready_o SHALL be combinational: en && (level + inflight) < DEPTH, where inflight is a 1-bit register set when a read is issued.
REQ-020 Accept = addr_valid_i && addr_ready_o; on accept mem_re_o=1 and mem_addr_o=addr_i in the same cycle; otherwise mem_re_o=0 and mem_addr_o=0.
REQ-021 inflight SHALL be set the cycle after an accept and cleared otherwise; when inflight=1, mem_rdata_i SHALL be pushed into the FIFO on that edge.
REQ-022 pe_valid_o = (level != 0); pe_data_o = head entry, registered storage, no combinational path from mem_rdata_i.
REQ-023 Pop = pe_valid_o && pe_ready_i; simultaneous push and pop leaves level unchanged and keeps word order.
REQ-024 Latency: accept in cycle N with empty FIFO -> pe_valid_o high in cycle N+2.
REQ-025 Throughput: one word per cycle sustained while pe_ready_i=1.
REQ-026 Overflow is impossible by REQ-019; a push with level==DEPTH is a design error and SHALL assert in simulation.
REQ-027 Window counter (0..WINDOW_LEN-1) increments on each pop, wraps to 0 after WINDOW_LEN-1; pe_last_o = pe_valid_o && counter==WINDOW_LEN-1.
REQ-028 en low SHALL flush: level=0, pointers=0, inflight=0, window counter=0, addr_ready_o=0; read data returning in the flush cycle or the cycle after is discarded.
REQ-029 Pointers wrap modulo DEPTH; level saturates at neither bound (guaranteed by REQ-019).

Reset
REQ-030 On reset_n low, asynchronously: level=0, pointers=0, inflight=0, window counter=0.
REQ-031 Outputs during reset: pe_valid_o=0, pe_last_o=0, mem_re_o=0, addr_ready_o=0, level_o=0; pe_data_o=0.
REQ-032 First accept is possible in the first cycle with reset_n high and en high.

Structure
REQ-033 DATA_W, ADDR_W, DEPTH, WINDOW_LEN defaults SHALL live in shared package fused_cnn_pkg.
REQ-034 FIFO storage/pointers SHALL be a sub-module sync_fifo (push, pop, flush, level, head data); credit and window logic stay in ifm_fetch_buffer.

Verification
REQ-035 Stream 45 addresses 0..44, memory model data = addr[7:0], pe_ready_i=1 -> 45 words 0..44 in order, first at accept+2, pe_last_o only on word 44.
REQ-036 pe_ready_i=0 with continuous requests -> exactly 4 accepts, addr_ready_o low afterwards, level_o=4, no lost or duplicated word after pe_ready_i rises.
REQ-037 Simultaneous push and pop at level=2 for 10 cycles -> level_o stays 2, data order preserved.
REQ-038 en dropped for 1 cycle with level=3 and inflight=1 -> level_o=0, pe_valid_o=0 next cycle, stale word never reaches PE, window counter restarts at 0.
REQ-039 reset_n asserted mid-stream (asynchronous, between edges) -> all outputs per REQ-031 immediately; 90 words after release -> pe_last_o on words 44 and 89.
REQ-040 Random pe_ready_i (50%) over 1000 words -> scoreboard match, pe_last_o every 45th pop, occupancy never exceeds DEPTH.
